// File: rtl/audio_pkg.sv
// Shared types and sizing helpers for the audio mixer slice.
package audio_pkg;

    localparam int AUDIO_DW_DEFAULT = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        ACCUM = 2'd2,
        SAT   = 2'd3
    } mix_state_t;

    // Headroom of clog2(n) bits lets n full-scale words sum without wrapping.
    function automatic int acc_dw(input int dw, input int n);
        return dw + $clog2(n);
    endfunction

endpackage

// File: rtl/audio_prefilter.sv
// Single-lane prefilter: an input with its MSB set pins the output to full scale.
module audio_prefilter
    import audio_pkg::*;
#(
    parameter int AUDIO_DW = AUDIO_DW_DEFAULT
) (
    input  logic [AUDIO_DW-1:0] din,
    output logic [AUDIO_DW-1:0] dout
);

    // Clamp on MSB, otherwise pass the lower bits through.
    always_comb begin
        if (din[AUDIO_DW-1]) begin
            dout = {AUDIO_DW{1'b1}};
        end else begin
            dout = {1'b0, din[AUDIO_DW-2:0]};
        end
    end

endmodule

// File: rtl/audio_mix_sequencer.sv
// Time-multiplexed stereo mixer sharing one prefilter lane across NUM_CH sources.
// Optional request queueing is enabled by defining AUDIO_MIX_PENDING_EN.
module audio_mix_sequencer
    import audio_pkg::*;
#(
    parameter int AUDIO_DW = AUDIO_DW_DEFAULT,
    parameter int NUM_CH   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_req,
    input  logic [NUM_CH*AUDIO_DW-1:0] ch_data,
    input  logic [NUM_CH-1:0]          ch_en_l,
    input  logic [NUM_CH-1:0]          ch_en_r,
    output logic [AUDIO_DW-1:0]        dout_l,
    output logic [AUDIO_DW-1:0]        dout_r,
    output logic                       dout_valid,
    output logic                       busy,
    output logic                       overrun
);

    localparam int ACC_W = acc_dw(AUDIO_DW, NUM_CH);
    localparam int IDX_W = $clog2(NUM_CH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [ACC_W-1:0] SAT_LIM  = {{(ACC_W-AUDIO_DW){1'b0}}, {AUDIO_DW{1'b1}}};

    mix_state_t          state_r;
    logic [IDX_W-1:0]    idx_r;
    logic [ACC_W-1:0]    acc_l_r;
    logic [ACC_W-1:0]    acc_r_r;
    logic [AUDIO_DW-1:0] snap_r [NUM_CH];
    logic [NUM_CH-1:0]   en_l_r;
    logic [NUM_CH-1:0]   en_r_r;
    logic [AUDIO_DW-1:0] pf_s;
    logic [ACC_W-1:0]    pf_ext_s;
    logic                busy_req_s;
    logic                drop_s;
    logic                hold_s;
`ifdef AUDIO_MIX_PENDING_EN
    logic                pending_r;
`endif

    function automatic logic [AUDIO_DW-1:0] sat_word(input logic [ACC_W-1:0] acc);
        if (acc >= SAT_LIM) begin
            return {AUDIO_DW{1'b1}};
        end else begin
            return acc[AUDIO_DW-1:0];
        end
    endfunction

    audio_prefilter #(
        .AUDIO_DW (AUDIO_DW)
    ) u_prefilter (
        .din  (snap_r[idx_r]),
        .dout (pf_s)
    );

    assign pf_ext_s   = {{(ACC_W-AUDIO_DW){1'b0}}, pf_s};
    assign busy_req_s = sample_req && (state_r != IDLE);

    // A request arriving outside IDLE is either queued (one deep) or dropped.
    always_comb begin
`ifdef AUDIO_MIX_PENDING_EN
        if (pending_r) begin
            drop_s = busy_req_s;
            hold_s = 1'b0;
        end else begin
            drop_s = 1'b0;
            hold_s = busy_req_s;
        end
`else
        drop_s = busy_req_s;
        hold_s = 1'b0;
`endif
    end

    // Sequencer FSM with index counter, accumulators and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            idx_r      <= {IDX_W{1'b0}};
            acc_l_r    <= {ACC_W{1'b0}};
            acc_r_r    <= {ACC_W{1'b0}};
            en_l_r     <= {NUM_CH{1'b0}};
            en_r_r     <= {NUM_CH{1'b0}};
            for (int k = 0; k < NUM_CH; k++) begin
                snap_r[k] <= {AUDIO_DW{1'b0}};
            end
            dout_l     <= {AUDIO_DW{1'b0}};
            dout_r     <= {AUDIO_DW{1'b0}};
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
`ifdef AUDIO_MIX_PENDING_EN
            pending_r  <= 1'b0;
`endif
        end else begin
            dout_valid <= 1'b0;
            overrun    <= drop_s;
`ifdef AUDIO_MIX_PENDING_EN
            if (hold_s) begin
                pending_r <= 1'b1;
            end else begin
                pending_r <= pending_r;
            end
`endif
            case (state_r)
                IDLE: begin
                    if (sample_req) begin
                        state_r <= LATCH;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LATCH: begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        snap_r[k] <= ch_data[k*AUDIO_DW +: AUDIO_DW];
                    end
                    en_l_r  <= ch_en_l;
                    en_r_r  <= ch_en_r;
                    acc_l_r <= {ACC_W{1'b0}};
                    acc_r_r <= {ACC_W{1'b0}};
                    idx_r   <= {IDX_W{1'b0}};
                    state_r <= ACCUM;
                end
                ACCUM: begin
                    if (en_l_r[idx_r]) begin
                        acc_l_r <= acc_l_r + pf_ext_s;
                    end else begin
                        acc_l_r <= acc_l_r;
                    end
                    if (en_r_r[idx_r]) begin
                        acc_r_r <= acc_r_r + pf_ext_s;
                    end else begin
                        acc_r_r <= acc_r_r;
                    end
                    if (idx_r == IDX_LAST) begin
                        state_r <= SAT;
                    end else begin
                        idx_r <= idx_r + IDX_ONE;
                    end
                end
                SAT: begin
                    dout_l     <= sat_word(acc_l_r);
                    dout_r     <= sat_word(acc_r_r);
                    dout_valid <= 1'b1;
`ifdef AUDIO_MIX_PENDING_EN
                    // A queued request (or one landing now) restarts without an IDLE gap.
                    pending_r <= 1'b0;
                    if (pending_r || hold_s) begin
                        state_r <= LATCH;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
`else
                    state_r <= IDLE;
                    busy    <= 1'b0;
`endif
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/audio_mix_sequencer.md
# audio_mix_sequencer

Time-multiplexed audio mixer that shares one `audio_prefilter` lane among `NUM_CH` unsigned audio sources and produces a saturated stereo sample on each sample request. It sits between the per-source audio generators (beeper, AY channels, DAC ports) and the output DAC/I2S serializer. It sequences one channel per clock through the prefilter, accumulates into left/right sums under per-channel routing enables, then clips the result to `AUDIO_DW` bits.

## Interface
- `AUDIO_DW`, 13, sample width of every input and output (unsigned).
- `NUM_CH`, 4, number of sources; 2..16.
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `sample_req` in 1: one-cycle strobe requesting a new mixed sample.
- `ch_data` in `NUM_CH*AUDIO_DW`: channel k occupies bits `[k*AUDIO_DW +: AUDIO_DW]`.
- `ch_en_l` in `NUM_CH`: bit k routes channel k to the left sum.
- `ch_en_r` in `NUM_CH`: bit k routes channel k to the right sum.
- `dout_l` out `AUDIO_DW`: mixed left sample, held until the next update.
- `dout_r` out `AUDIO_DW`: mixed right sample, held until the next update.
- `dout_valid` out 1: one-cycle pulse when `dout_l`/`dout_r` update.
- `busy` out 1: high from the cycle after an accepted request until `dout_valid`.
- `overrun` out 1: one-cycle pulse when a request is dropped.

## Operation
- States: IDLE, LATCH, ACCUM, SAT.
- IDLE: on `sample_req` -> LATCH.
- LATCH (1 cycle): snapshot `ch_data`, `ch_en_l`, `ch_en_r` into registers; clear `acc_l`, `acc_r`; channel index `idx` = 0 -> ACCUM.
- ACCUM (`NUM_CH` cycles): the snapshot word `idx` drives the shared prefilter. Prefilter rule: if the input MSB is 1, the output is all ones; otherwise the output is `{0, din[AUDIO_DW-2:0]}`. The prefiltered value is added to `acc_l` if `en_l[idx]`, and to `acc_r` if `en_r[idx]`. When `idx == NUM_CH-1`, go to SAT; otherwise increment `idx`.
- Accumulators are `AUDIO_DW + $clog2(NUM_CH)` bits wide and cannot overflow.
- SAT (1 cycle): each output is all ones if `acc >= 2**AUDIO_DW - 1`, otherwise `acc[AUDIO_DW-1:0]`. It registers into `dout_l`/`dout_r`, pulses `dout_valid`, then returns to IDLE, or to LATCH if a request is pending.
- A disabled channel contributes 0. With all enables clear, the output is 0.
- `sample_req` while not IDLE is handled per Configuration.
- `sample_req` in the same cycle as SAT counts as arriving while busy.
- Reset, including mid-sequence, forces IDLE and clears `idx`, accumulators, pending flag, `dout_l`, `dout_r`, `dout_valid`, `busy` and `overrun`. Partial sums are discarded and no `dout_valid` is issued.

## Timing
- `sample_req` at cycle t (IDLE) -> LATCH at t+1 -> ACCUM t+2..t+1+NUM_CH -> SAT at t+2+NUM_CH.
- `dout_valid` and new outputs are visible at t+3+NUM_CH. Latency is NUM_CH+3 cycles; 7 at the default.
- `busy` is high t+1 .. t+2+NUM_CH.
- Minimum request spacing without pending or drop is NUM_CH+3 cycles.
- Inputs are sampled only in LATCH; changes afterwards affect only the next sample.
- All outputs are registered.

## Configuration
- `AUDIO_MIX_PENDING_EN` defined: a one-deep pending flag latches a request made while busy.
  - After SAT, the block enters LATCH directly with no IDLE cycle.
  - A second request while pending is already set is dropped and pulses `overrun` the next cycle.
- `AUDIO_MIX_PENDING_EN` undefined: every request while busy is dropped and pulses `overrun` the next cycle. The pending flag does not exist.

## Structure
- Shared package `audio_pkg`: state enum type (IDLE/LATCH/ACCUM/SAT), `AUDIO_DW_DEFAULT` = 13, and the accumulator width function `acc_dw(AUDIO_DW, NUM_CH)`.
- One sub-module instance: `audio_prefilter` (existing block, `AUDIO_DW` passed through), fed by the indexed snapshot word. It is the only prefilter in the mixer.
- FSM, index counter, accumulators and saturation stay in this module.

## Test plan
- Defaults; ch0..3 = 100, 200, 300, 400; `ch_en_l` = 4'b1111, `ch_en_r` = 4'b0101; one request -> `dout_valid` exactly 7 cycles later, `dout_l` = 1000, `dout_r` = 400.
- ch0 = 13'h1000 (MSB set), others 0, all enabled -> `dout_l` = `dout_r` = 13'h1FFF.
- All channels = 13'h0FFF, all enabled -> sum 16380 is clipped to `dout_l` = `dout_r` = 13'h1FFF.
- Two requests 2 cycles apart:
  - With `AUDIO_MIX_PENDING_EN` defined -> two `dout_valid` pulses 7 cycles apart, `overrun` never set.
  - With `AUDIO_MIX_PENDING_EN` undefined -> one `dout_valid`, `overrun` pulses once.
- `reset` asserted in the 3rd ACCUM cycle -> `dout_valid` stays low, all outputs 0, `busy` 0. The next request produces a correct sum.
- Change `ch_data` and enables in the cycle after LATCH -> output reflects the LATCH snapshot only.
